// File: rtl/demux_router.sv
// demux_router
//   Four-way registered demultiplexer. Each accepted input word is queued in
//   the FIFO selected by sel and presented on that port with valid/ready.
//   Back-pressure applies per destination.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low; flushes every FIFO
//   in         input data word
//   sel        destination index 0..3
//   in_valid   in/sel valid this cycle
//   in_ready   destination selected by sel is not full
//   out        packed head words, out[i*NUM_OF_BITS +: NUM_OF_BITS] = port i
//   out_valid  per-port non-empty flags
//   out_ready  per-port consumer take
//   count      per-port 8-bit delivered-word counters, packed
//
// Configuration macro
//   DEMUX_STATS_EN  builds the per-port delivered-word counters; when it is
//                   undefined, count is tied to zero.
module demux_router #(
  parameter int NUM_OF_BITS = 4,
  parameter int DEPTH       = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_OF_BITS-1:0]   in,
  input  logic [1:0]               sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [4*NUM_OF_BITS-1:0] out,
  output logic [3:0]               out_valid,
  input  logic [3:0]               out_ready,
  output logic [31:0]              count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [3:0] full;

  // Only registered full flags feed in_ready, so no bypass from a same-cycle pop.
  assign in_ready = !full[sel];

  for (genvar i = 0; i < 4; i++) begin : g_port
    logic [NUM_OF_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [OW-1:0]          occ;
    logic                   push;
    logic                   pop;

    assign full[i]      = (occ == OW'(DEPTH));
    assign out_valid[i] = (occ != '0);
    assign push         = in_valid && !full[i] && (sel == 2'(i));
    assign pop          = out_valid[i] && out_ready[i];

    // Storage is cleared on reset so the head word reads as zero while flushed.
    assign out[i*NUM_OF_BITS +: NUM_OF_BITS] = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem[j] <= '0;
        end
      end else begin
        if (push) begin
          mem[wr_ptr] <= in;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt;

    // Wraps 255 -> 0 by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (pop) begin
        cnt <= cnt + 8'd1;
      end
    end

    assign count[i*8 +: 8] = cnt;
`else
    assign count[i*8 +: 8] = 8'd0;
`endif
  end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router
//   Directed bench for demux_router with hand-computed expectations.
module tb_demux_router;

  logic        clock;
  logic        reset;
  logic [3:0]  in;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] count;

  int checks;
  int errors;

  demux_router #(.NUM_OF_BITS(4), .DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] stats_exp;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in        = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_count", count, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    #2 reset = 1'b1;
    tick();

    // Load FIFO 2 with two words, then reset mid-stream
    in = 4'h5; sel = 2'd2; in_valid = 1'b1;
    #1 chk("pre_in_ready", 32'(in_ready), 32'h1);
    tick();
    in = 4'h6;
    tick();
    in_valid = 1'b0;
    chk("f2_valid", 32'(out_valid), 32'h4);
    chk("f2_head", 32'(out[11:8]), 32'h5);
    chk("f2_full", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_count", count, 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    in = 4'h7; in_valid = 1'b1;
    tick();
    chk("rst_no_push", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    // Single route
    in = 4'hA; sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'h4);
    chk("single_out", 32'(out[11:8]), 32'hA);
    tick();
    chk("single_hold_valid", 32'(out_valid), 32'h4);
    chk("single_hold_out", 32'(out[11:8]), 32'hA);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("single_drained", 32'(out_valid), 32'h0);

    // Back-pressure on port 1
    sel = 2'd1; in_valid = 1'b1; in = 4'h1;
    tick();
    in = 4'h2;
    tick();
    in = 4'h3;
    chk("bp_stall", 32'(in_ready), 32'h0);
    tick();
    chk("bp_stall2", 32'(in_ready), 32'h0);
    chk("bp_valid", 32'(out_valid), 32'h2);
    chk("bp_head1", 32'(out[7:4]), 32'h1);
    out_ready = 4'b0010;
    tick();
    chk("bp_recover", 32'(in_ready), 32'h1);
    chk("bp_head2", 32'(out[7:4]), 32'h2);
    tick();
    in_valid = 1'b0;
    chk("bp_head3", 32'(out[7:4]), 32'h3);
    chk("bp_valid3", 32'(out_valid), 32'h2);
    tick();
    out_ready = 4'b0000;
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Independence: port 0 full, port 3 still accepts
    sel = 2'd0; in_valid = 1'b1; in = 4'h8;
    tick();
    in = 4'h9;
    tick();
    chk("ind_p0_full", 32'(in_ready), 32'h0);
    sel = 2'd3; in = 4'hC;
    #1 chk("ind_p3_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("ind_valid", 32'(out_valid), 32'h9);
    chk("ind_p3_out", 32'(out[15:12]), 32'hC);
    chk("ind_p0_out", 32'(out[3:0]), 32'h8);
    out_ready = 4'b1001;
    tick();
    chk("ind_after_pop", 32'(out_valid), 32'h1);
    chk("ind_p0_next", 32'(out[3:0]), 32'h9);
    tick();
    out_ready = 4'b0000;
    chk("ind_empty", 32'(out_valid), 32'h0);

    // Streaming round-robin with all consumers ready
    out_ready = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      in = 4'(k); sel = 2'(k % 4); in_valid = 1'b1;
      #1 chk("stream_ready", 32'(in_ready), 32'h1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
      chk("stream_out", 32'(out[(k % 4)*4 +: 4]), 32'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Stats: 260 pops on port 0 after a fresh reset
    reset = 1'b0;
    #2 chk("stats_rst", count, 32'h0);
    reset = 1'b1;
    tick();
    out_ready = 4'b0001; sel = 2'd0; in_valid = 1'b1;
    for (int k = 0; k < 260; k++) begin
      in = 4'(k);
      #1 chk("stats_ready", 32'(in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
    stats_exp = 8'd4;
`else
    stats_exp = 8'd0;
`endif
    chk("stats_empty", 32'(out_valid), 32'h0);
    chk("stats_count0", 32'(count[7:0]), 32'(stats_exp));
    chk("stats_other", 32'(count[31:8]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_router.md
# demux_router

Four-way registered demultiplexer: the inverse of the 4:1 routing mux. A single input stream carries a NUM_OF_BITS word plus a 2-bit destination select. Each accepted word is queued into one of four per-destination FIFOs and presented on that destination's output with a valid/ready handshake. It sits downstream of a shared bus and fans traffic out to four independent consumers, with back-pressure applied per destination.

## Interface
- NUM_OF_BITS, 4, width of every data word
- DEPTH, 2, entries per output FIFO (power of two, ≥2)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- IN  input  NUM_OF_BITS  input data word
- SEL  input  2  destination index 0..3
- IN_VALID  input  1  IN/SEL valid this cycle
- IN_READY  output  1  router can accept the word addressed by SEL
- OUT  output  4×NUM_OF_BITS  packed; OUT[i] is the head word of FIFO i
- OUT_VALID  output  4  OUT_VALID[i] is 1 when FIFO i is non-empty
- OUT_READY  input  4  consumer i takes the head word
- COUNT  output  4×8  per-port delivered-word counters (only with DEMUX_STATS_EN; tied to 0 otherwise)

## Operation
- IN_READY = !full[SEL]. It is combinational from SEL and the registered full flags only.
- Push: IN_VALID && IN_READY. {IN} is written at the tail of FIFO[SEL]; the other FIFOs are untouched.
- Pop on port i: OUT_VALID[i] && OUT_READY[i]. The head of FIFO i advances.
- FIFO i state:
  - read pointer, write pointer, and occupancy counter of width $clog2(DEPTH)+1.
  - full = (occ == DEPTH); empty = (occ == 0).
  - Pointers wrap modulo DEPTH.
- Occupancy update per port:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen in the same cycle; both pointers advance.
- Full port with a simultaneous pop: IN_READY remains 0 for that cycle (no bypass). The word is accepted on the following cycle.
- Push and pop on different ports in the same cycle are independent.
- OUT[i] is driven from storage at the read pointer. Its value is don't-care while OUT_VALID[i] = 0, but it must be stable while OUT_VALID[i] = 1 and OUT_READY[i] = 0.
- IN_VALID = 0: no state change on the input side. SEL may change freely, and IN_READY follows SEL.
- Ordering: words sent to the same port leave in arrival order. No ordering holds across ports.

## Timing
- Reset asserted, at any time including mid-transfer:
  - all FIFOs flush; pointers and occupancy go to 0.
  - OUT_VALID = 4'b0000, OUT = 0, COUNT = 0.
  - IN_READY = 1 for any SEL once reset is asserted, but no push occurs while reset is low.
- First edge after reset release: normal operation.
- Latency: a word pushed at edge N is visible on OUT[SEL] with OUT_VALID high after edge N (one cycle).
- Throughput: one push per cycle sustained, provided the target port's consumer pops every cycle and occ < DEPTH.
- Full recovery: pop at edge N makes full = 0 after N, so IN_READY rises in the cycle following the pop.
- Push into an empty FIFO with OUT_READY already high: the word is popped at the next edge after it becomes visible. Occupancy returns to 0 at N+1.

## Configuration
- DEMUX_STATS_EN defined:
  - COUNT[i] is an 8-bit counter incremented on every pop of port i.
  - It wraps 255 → 0 and is cleared by reset.
- DEMUX_STATS_EN undefined:
  - no counter registers are built; COUNT is driven to all zeros.
  - all other behaviour is identical.

## Test plan
- Reset then idle: hold reset low mid-stream with FIFO 2 holding 2 words → OUT_VALID = 0000, COUNT = 0. After release, IN_READY = 1.
- Single route: IN = 4'hA, SEL = 2, IN_VALID one cycle, OUT_READY = 0000 → next cycle OUT_VALID = 0100 and OUT[2] = 4'hA. The other ports remain invalid.
- Back-pressure: push 4'h1, 4'h2, 4'h3 to SEL = 1 with OUT_READY[1] = 0 → the third word stalls with IN_READY = 0. Raise OUT_READY[1] → port 1 delivers 1, 2, 3 in order, and the third push is accepted the cycle after the first pop.
- Independence: FIFO 0 full, then push to SEL = 3 → IN_READY = 1, and port 3 receives the word while port 0 is unaffected.
- Streaming: OUT_READY = 1111, push 4'h0..4'hF round-robin over SEL 0..3 → one push per cycle, never stalled. Each port outputs its four words in order with one-cycle latency.
- Stats (DEMUX_STATS_EN): 260 pops on port 0 → COUNT[0] = 4. Without the macro → COUNT = 0 throughout.
